// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster timing constants shared by the sync generator and renderers.
package vga_timing_pkg;
    localparam int CNT_W       = 10;
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 783;
    localparam int V_TOTAL     = 521;
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 32;
    localparam int V_ACT_END   = 511;
endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV; wrap marks the edge the raster advances, pix_tick is its registered echo.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick,
    output logic wrap
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div;
    assign wrap = div == DW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            div      <= wrap ? '0 : div + 1'b1;
            pix_tick <= wrap;
        end
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters with HS/VS/InDisplay decoded from next-state counters so all outputs change together.
// Define VGA_FRAME_CNT_EN to add the frame_cnt/frame_start outputs.
module vga_sync_gen
    import vga_timing_pkg::CNT_W;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int H_ACT_END   = vga_timing_pkg::H_ACT_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int V_ACT_END   = vga_timing_pkg::V_ACT_END
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] Coloana,
    output logic [CNT_W-1:0] Linie,
    output logic             HS,
    output logic             VS,
    output logic             InDisplay,
    output logic             pix_tick
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt,
    output logic             frame_start
`endif
);
    logic             wrap, h_end, v_end;
    logic [CNT_W-1:0] col_n, lin_n;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick),
        .wrap     (wrap)
    );

    assign h_end = Coloana == CNT_W'(H_TOTAL - 1);
    assign v_end = Linie == CNT_W'(V_TOTAL - 1);

    always_comb begin
        col_n = h_end ? '0 : Coloana + 1'b1;
        lin_n = !h_end ? Linie : v_end ? '0 : Linie + 1'b1;
    end

    // Decode the values being loaded, not the current ones, so sync/enable never lag the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Coloana   <= '0;
            Linie     <= '0;
            HS        <= 1'b0;
            VS        <= 1'b0;
            InDisplay <= 1'b0;
        end else if (wrap) begin
            Coloana   <= col_n;
            Linie     <= lin_n;
            HS        <= col_n >= CNT_W'(H_SYNC);
            VS        <= lin_n >= CNT_W'(V_SYNC);
            InDisplay <= col_n >= CNT_W'(H_ACT_START) && col_n <= CNT_W'(H_ACT_END) &&
                         lin_n >= CNT_W'(V_ACT_START) && lin_n <= CNT_W'(V_ACT_END);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic frame_edge;
    assign frame_edge = wrap && h_end && v_end;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_edge;
            frame_cnt   <= frame_edge ? frame_cnt + 1'b1 : frame_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks three vga_sync_gen builds (default 640x480, and a tiny raster at CLK_DIV 1 and 3)
// against an arithmetic model of position versus clocks since reset. Frame outputs checked when VGA_FRAME_CNT_EN is defined.
module tb_vga_sync_gen;
    typedef struct packed {
        logic [9:0] col;
        logic [9:0] lin;
        logic       hs;
        logic       vs;
        logic       ind;
        logic       tick;
    } obs_t;
    typedef struct {
        int   inst;
        int   k;
        obs_t exp;
    } vec_t;

    localparam int DV [3]  = '{4, 1, 3};
    localparam int HT [3]  = '{800, 12, 12};
    localparam int HSY[3]  = '{96, 3, 3};
    localparam int HAS[3]  = '{144, 4, 4};
    localparam int HAE[3]  = '{783, 9, 9};
    localparam int VT [3]  = '{521, 6, 6};
    localparam int VSY[3]  = '{2, 2, 2};
    localparam int VAS[3]  = '{32, 2, 2};
    localparam int VAE[3]  = '{511, 4, 4};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] col [3];
    logic [9:0] lin [3];
    logic       hs [3];
    logic       vs [3];
    logic       ind [3];
    logic       tick [3];
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fcnt [3];
    logic       fst [3];
    int         fst_pulses = 0;
`endif
    int k = 0;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit phase0 = 1'b0;
    int a_hs_low = 0, b_ind = 0, b_vs_low = 0, b_hs_low = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(.CLK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .Coloana(col[0]), .Linie(lin[0]), .HS(hs[0]), .VS(vs[0]),
        .InDisplay(ind[0]), .pix_tick(tick[0])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fcnt[0]), .frame_start(fst[0])
`endif
    );
    vga_sync_gen #(.CLK_DIV(1), .H_TOTAL(12), .H_SYNC(3), .H_ACT_START(4), .H_ACT_END(9),
                   .V_TOTAL(6), .V_SYNC(2), .V_ACT_START(2), .V_ACT_END(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .Coloana(col[1]), .Linie(lin[1]), .HS(hs[1]), .VS(vs[1]),
        .InDisplay(ind[1]), .pix_tick(tick[1])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fcnt[1]), .frame_start(fst[1])
`endif
    );
    vga_sync_gen #(.CLK_DIV(3), .H_TOTAL(12), .H_SYNC(3), .H_ACT_START(4), .H_ACT_END(9),
                   .V_TOTAL(6), .V_SYNC(2), .V_ACT_START(2), .V_ACT_END(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .Coloana(col[2]), .Linie(lin[2]), .HS(hs[2]), .VS(vs[2]),
        .InDisplay(ind[2]), .pix_tick(tick[2])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fcnt[2]), .frame_start(fst[2])
`endif
    );

    // Clocks seen since reset released; the whole model is a function of this count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    function automatic obs_t model(int kk, int i);
        obs_t m;
        int n, c, l;
        n = kk / DV[i];
        c = n % HT[i];
        l = (n / HT[i]) % VT[i];
        m.col  = 10'(c);
        m.lin  = 10'(l);
        m.hs   = c >= HSY[i];
        m.vs   = l >= VSY[i];
        m.ind  = c >= HAS[i] && c <= HAE[i] && l >= VAS[i] && l <= VAE[i];
        m.tick = kk > 0 && kk % DV[i] == 0;
        return m;
    endfunction

    function automatic obs_t mk(int c, int l, bit h, bit v, bit d, bit t);
        obs_t m;
        m = {10'(c), 10'(l), h, v, d, t};
        return m;
    endfunction

    task automatic cmp_all(string tag);
        for (int i = 0; i < 3; i++) begin
            obs_t got, exp;
            got = {col[i], lin[i], hs[i], vs[i], ind[i], tick[i]};
            exp = model(k, i);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s inst%0d k=%0d got col=%0d lin=%0d hs,vs,ind,tick=%b%b%b%b want col=%0d lin=%0d hs,vs,ind,tick=%b%b%b%b",
                         tag, i, k, got.col, got.lin, got.hs, got.vs, got.ind, got.tick,
                         exp.col, exp.lin, exp.hs, exp.vs, exp.ind, exp.tick);
            end
`ifdef VGA_FRAME_CNT_EN
            begin
                int n, fr;
                logic [7:0] efc;
                logic efs;
                n   = k / DV[i];
                fr  = HT[i] * VT[i];
                efc = 8'((n / fr) % 256);
                efs = k > 0 && k % DV[i] == 0 && n > 0 && n % fr == 0;
                checks++;
                if (fcnt[i] !== efc || fst[i] !== efs) begin
                    failures++;
                    $display("FAIL %s_frame inst%0d k=%0d got frame_cnt=%0d frame_start=%b want %0d %b",
                             tag, i, k, fcnt[i], fst[i], efc, efs);
                end
            end
`endif
        end
    endtask

    task automatic check_int(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) cmp_all("model");

    always @(negedge clk) begin
        if (phase0 && rst_n && k >= 1 && k <= 3200) a_hs_low += hs[0] ? 0 : 1;
        if (phase0 && rst_n && k >= 1 && k <= 72) begin
            b_ind    += ind[1] ? 1 : 0;
            b_vs_low += vs[1] ? 0 : 1;
            b_hs_low += hs[1] ? 0 : 1;
        end
`ifdef VGA_FRAME_CNT_EN
        if (phase0 && rst_n && k >= 1 && k <= 72) fst_pulses += fst[1] ? 1 : 0;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog k=%0d want bench to have finished", k);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[17];
        tbl[0]  = '{0, 3,    mk(0,   0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 4,    mk(1,   0, 0, 0, 0, 1)};
        tbl[2]  = '{0, 5,    mk(1,   0, 0, 0, 0, 0)};
        tbl[3]  = '{1, 27,   mk(3,   2, 1, 1, 0, 1)};
        tbl[4]  = '{1, 28,   mk(4,   2, 1, 1, 1, 1)};
        tbl[5]  = '{1, 57,   mk(9,   4, 1, 1, 1, 1)};
        tbl[6]  = '{1, 58,   mk(10,  4, 1, 1, 0, 1)};
        tbl[7]  = '{1, 60,   mk(0,   5, 0, 1, 0, 1)};
        tbl[8]  = '{1, 71,   mk(11,  5, 1, 1, 0, 1)};
        tbl[9]  = '{1, 72,   mk(0,   0, 0, 0, 0, 1)};
        tbl[10] = '{0, 380,  mk(95,  0, 0, 0, 0, 1)};
        tbl[11] = '{0, 384,  mk(96,  0, 1, 0, 0, 1)};
        tbl[12] = '{0, 387,  mk(96,  0, 1, 0, 0, 0)};
        tbl[13] = '{0, 3196, mk(799, 0, 1, 0, 0, 1)};
        tbl[14] = '{0, 3200, mk(0,   1, 0, 0, 0, 1)};
        tbl[15] = '{0, 6400, mk(0,   2, 0, 1, 0, 1)};
        tbl[16] = '{0, 6976, mk(144, 2, 1, 1, 0, 1)};

        repeat (3) @(negedge clk);
        cmp_all("reset_hold");
        chk_en = 1'b1;
        phase0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            obs_t got;
            repeat (tbl[i].k - k) @(negedge clk);
            got = {col[tbl[i].inst], lin[tbl[i].inst], hs[tbl[i].inst], vs[tbl[i].inst],
                   ind[tbl[i].inst], tick[tbl[i].inst]};
            checks++;
            if (got !== tbl[i].exp) begin
                failures++;
                $display("FAIL vec%0d inst%0d k=%0d got col=%0d lin=%0d hs,vs,ind,tick=%b%b%b%b want col=%0d lin=%0d hs,vs,ind,tick=%b%b%b%b",
                         i, tbl[i].inst, k, got.col, got.lin, got.hs, got.vs, got.ind, got.tick,
                         tbl[i].exp.col, tbl[i].exp.lin, tbl[i].exp.hs, tbl[i].exp.vs,
                         tbl[i].exp.ind, tbl[i].exp.tick);
            end
        end
        phase0 = 1'b0;
        check_int("hs_low_clks", a_hs_low, 384);
        check_int("small_ind_ticks", b_ind, 18);
        check_int("small_vs_low_ticks", b_vs_low, 24);
        check_int("small_hs_low_ticks", b_hs_low, 18);
`ifdef VGA_FRAME_CNT_EN
        check_int("frame_start_pulses", fst_pulses, 1);
`endif

        // Mid-frame async reset with the small raster at (6,3), then a clean restart.
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (42) @(negedge clk);
        check_int("midframe_col", int'(col[1]), 6);
        check_int("midframe_lin", int'(lin[1]), 3);
        #2 rst_n = 1'b0;
        #1 cmp_all("async_midframe");
        check_int("async_pix_tick", int'(tick[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);

        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            #($urandom_range(1, 4)) rst_n = 1'b0;
            #1 cmp_all("async_rand");
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end

`ifdef VGA_FRAME_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * 72) @(negedge clk);
        check_int("frame_cnt_3", int'(fcnt[1]), 3);
        repeat (255 * 72 - k) @(negedge clk);
        check_int("frame_cnt_255", int'(fcnt[1]), 255);
        repeat (72) @(negedge clk);
        check_int("frame_cnt_wrap", int'(fcnt[1]), 0);
        check_int("frame_start_wrap", int'(fst[1]), 1);
`endif
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
